// File: rtl/sdrc_bridge_pkg.sv
// Shared types for the Wishbone to SDRAM-controller request bridge.
package sdrc_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WDATA,
        RDATA,
        ACK,
        ERR
    } state_t;

    localparam logic [8:0] APP_LEN_ONE = 9'd1;

endpackage

// File: rtl/sdrc_bridge_wdt.sv
// Per-phase watchdog: counts while enabled, restarts on clear, flags the last allowed cycle.
module sdrc_bridge_wdt #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    generate
        if (TIMEOUT_CYC == 0) begin : g_disabled
            logic unused_wdt_inputs;
            assign unused_wdt_inputs = clk ^ srst ^ clear ^ enable;
            assign expired = 1'b0;
        end else begin : g_counter
            logic [CW-1:0] count_reg;

            always_ff @(posedge clk) begin
                if (srst || clear) begin
                    count_reg <= '0;
                end else if (enable) begin
                    count_reg <= count_reg + 1'b1;
                end
            end

            assign expired = enable && (count_reg == CW'(TIMEOUT_CYC - 1));
        end
    endgenerate

endmodule

// File: rtl/wb2sdrc_req_bridge.sv
// Classic single-beat Wishbone slave that issues one len=1 request per cycle to an SDR
// controller application port, then moves the write/read data phase and acks the master.
module wb2sdrc_req_bridge
    import sdrc_bridge_pkg::*;
#(
    parameter  int SDR_DW      = 16,
    parameter  int SDR_BW      = 2,
    parameter  int APP_AW      = 26,
    parameter  int TIMEOUT_CYC = 1024,
    localparam int BW_LSB      = $clog2(SDR_BW),
    localparam int WB_AW       = APP_AW + BW_LSB
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [WB_AW-1:0]  wb_adr_i,
    input  logic [SDR_BW-1:0] wb_sel_i,
    input  logic [SDR_DW-1:0] wb_dat_i,
    output logic [SDR_DW-1:0] wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              app_req_o,
    output logic [APP_AW-1:0] app_req_addr_o,
    output logic [8:0]        app_req_len_o,
    output logic              app_req_wr_n_o,
    input  logic              app_req_ack_i,
    output logic [SDR_DW-1:0] app_wr_data_o,
    output logic [SDR_BW-1:0] app_wr_en_n_o,
    input  logic              app_wr_next_req_i,
    input  logic [SDR_DW-1:0] app_rd_data_i,
    input  logic              app_rd_valid_i
);

    state_t              state_reg, state_next;
    logic                req_reg, req_next;
    logic [APP_AW-1:0]   addr_reg, addr_next;
    logic                wr_n_reg, wr_n_next;
    logic [SDR_BW-1:0]   en_n_reg, en_n_next;
    logic [SDR_DW-1:0]   wdata_reg, wdata_next;
    logic [SDR_DW-1:0]   rdata_reg, rdata_next;
    logic                ack_reg, ack_next;
    logic                err_reg, err_next;
    logic                abort_reg, abort_next;
    logic                wdt_clear, wdt_enable, wdt_expired;
    logic [SDR_BW-1:0]   sel_n;

    genvar gi;
    generate
        for (gi = 0; gi < SDR_BW; gi++) begin : g_lane
            assign sel_n[gi] = ~wb_sel_i[gi];
        end
        if (BW_LSB > 0) begin : g_adr_lsb
            logic unused_adr_lsb;
            assign unused_adr_lsb = ^wb_adr_i[BW_LSB-1:0];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        req_next   = req_reg;
        addr_next  = addr_reg;
        wr_n_next  = wr_n_reg;
        en_n_next  = en_n_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        ack_next   = 1'b0;
        err_next   = 1'b0;
        abort_next = abort_reg;
        case (state_reg)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i && !ack_reg && !err_reg) begin
                    addr_next  = wb_adr_i[WB_AW-1:BW_LSB];
                    wr_n_next  = ~wb_we_i;
                    en_n_next  = sel_n;
                    wdata_next = wb_dat_i;
                    req_next   = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                // An accepted request commits the controller, so a same-cycle cyc drop
                // only silences the eventual ack.
                if (app_req_ack_i) begin
                    req_next   = 1'b0;
                    abort_next = ~wb_cyc_i;
                    state_next = wr_n_reg ? RDATA : WDATA;
                end else if (!wb_cyc_i) begin
                    req_next   = 1'b0;
                    state_next = IDLE;
                end else if (wdt_expired) begin
                    req_next   = 1'b0;
                    err_next   = 1'b1;
                    state_next = ERR;
                end
            end
            WDATA: begin
                abort_next = abort_reg | ~wb_cyc_i;
                if (app_wr_next_req_i) begin
                    ack_next   = ~(abort_reg | ~wb_cyc_i);
                    state_next = ACK;
                end else if (wdt_expired) begin
                    err_next   = 1'b1;
                    state_next = ERR;
                end
            end
            RDATA: begin
                abort_next = abort_reg | ~wb_cyc_i;
                if (app_rd_valid_i) begin
                    rdata_next = app_rd_data_i;
                    ack_next   = ~(abort_reg | ~wb_cyc_i);
                    state_next = ACK;
                end else if (wdt_expired) begin
                    err_next   = 1'b1;
                    state_next = ERR;
                end
            end
            ACK: begin
                abort_next = 1'b0;
                state_next = IDLE;
            end
            ERR: begin
                req_next   = 1'b0;
                abort_next = 1'b0;
                state_next = IDLE;
            end
            default: begin
                req_next   = 1'b0;
                abort_next = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg <= IDLE;
            req_reg   <= 1'b0;
            addr_reg  <= '0;
            wr_n_reg  <= 1'b1;
            en_n_reg  <= '1;
            wdata_reg <= '0;
            rdata_reg <= '0;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
            abort_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            req_reg   <= req_next;
            addr_reg  <= addr_next;
            wr_n_reg  <= wr_n_next;
            en_n_reg  <= en_n_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            ack_reg   <= ack_next;
            err_reg   <= err_next;
            abort_reg <= abort_next;
        end
    end

    // The timer restarts on every state change so each phase gets its own budget.
    assign wdt_clear  = (state_next != state_reg);
    assign wdt_enable = (state_reg == REQ) || (state_reg == WDATA) || (state_reg == RDATA);

    sdrc_bridge_wdt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdt (
        .clk     (wb_clk_i),
        .srst    (wb_rst_i),
        .clear   (wdt_clear),
        .enable  (wdt_enable),
        .expired (wdt_expired)
    );

    assign wb_dat_o       = rdata_reg;
    assign wb_ack_o       = ack_reg;
    assign wb_err_o       = err_reg;
    assign app_req_o      = req_reg;
    assign app_req_addr_o = addr_reg;
    assign app_req_len_o  = APP_LEN_ONE;
    assign app_req_wr_n_o = wr_n_reg;
    assign app_wr_data_o  = wdata_reg;
    assign app_wr_en_n_o  = en_n_reg;

endmodule
